pe_array_sequencer: RTL and testbench

- Run-time sequencer for the 3x3 row-stationary PE array: it generates the per-group read strobes (PERead), start strobes (PEStart) and per-row filter-load strobes (filtRead).
- Sits between the shared 8-bit operand bus and the array.
  - Accepts a job, loads filter taps, then streams ifmap beats under a valid/ready handshake.
  - Propagates strobes diagonally across the 5 PE groups and flags array outputs.
- Replaces fixed-count control with a configurable job of cfg_w columns by cfg_rows output rows.

---
 rtl/pe_array_sequencer_if.sv | 28 ++
 rtl/pe_array_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_pe_array_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_sequencer_if.sv
// Operand-bus handshake, job configuration and array strobe bundle for
// pe_array_sequencer. master = job/operand source, slave = the sequencer.
interface pe_array_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] cfg_w;
  logic [CNT_W-1:0] cfg_rows;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       PERead;
  logic [4:0]       PEStart;
  logic [2:0]       filtRead;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, cfg_w, cfg_rows, in_valid,
    input  in_ready, PERead, PEStart, filtRead, out_valid, busy, done, err
  );

  modport slave (
    input  start, cfg_w, cfg_rows, in_valid,
    output in_ready, PERead, PEStart, filtRead, out_valid, busy, done, err
  );
endinterface

// File: rtl/pe_array_sequencer.sv
// Run-time sequencer for the 3x3 row-stationary PE array: filter load, ifmap
// streaming and diagonal strobe propagation. Optional macro SEQ_PERF_CNT_EN adds perf counters.
module pe_array_sequencer #(
  parameter int FILT_TAPS = 3,
  parameter int PE_LAT    = 2,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                nRST,
  pe_array_sequencer_if.slave bus
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0]         perf_busy_cycles,
  output logic [15:0]         perf_stall_cycles
`endif
);

  localparam int NUM_GROUPS = 5;
  localparam int NUM_ROWS   = 3;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD_FILT,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cfg_w_reg;
  logic [CNT_W-1:0] cfg_rows_reg;
  logic [CNT_W-1:0] col_reg;
  logic [CNT_W-1:0] row_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] rows_last;
  logic             fire;
  logic             fire_load;
  logic             fire_stream;
  logic             cfg_bad;
  logic             pipe_empty;

  logic [NUM_GROUPS-1:0] wave_all;
  logic [NUM_GROUPS-1:0] st_all;
  logic [PE_LAT:0]       ov_all;

  assign w_last      = cfg_w_reg - 1'b1;
  assign rows_last   = cfg_rows_reg - 1'b1;
  assign fire        = bus.in_valid && in_ready_reg;
  assign fire_load   = fire && (state_reg == LOAD_FILT);
  assign fire_stream = fire && (state_reg == STREAM);
  assign cfg_bad     = (cfg_w_reg < CNT_W'(FILT_TAPS)) || (cfg_rows_reg == '0);
  assign pipe_empty  = (wave_all == '0) && (st_all == '0) && (ov_all == '0);

  // Group 0 sees the fire combinationally; later groups are pure delay stages
  // that keep shifting regardless of in_valid.
  assign wave_all[0] = fire_stream;
  assign st_all[0]   = fire_stream && (col_reg >= CNT_W'(FILT_TAPS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GROUPS - 1; gi++) begin : g_stage
      logic wave_q;
      logic st_q;
      always_ff @(posedge clk) begin
        if (!nRST) begin
          wave_q <= 1'b0;
          st_q   <= 1'b0;
        end else begin
          wave_q <= wave_all[gi];
          st_q   <= st_all[gi];
        end
      end
      assign wave_all[gi+1] = wave_q;
      assign st_all[gi+1]   = st_q;
    end

    assign ov_all[0] = st_all[NUM_GROUPS-1];
    for (gi = 0; gi < PE_LAT; gi++) begin : g_out_lat
      logic ov_q;
      always_ff @(posedge clk) begin
        if (!nRST) begin
          ov_q <= 1'b0;
        end else begin
          ov_q <= ov_all[gi];
        end
      end
      assign ov_all[gi+1] = ov_q;
    end

    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_filt
      assign bus.filtRead[gi] = fire_load && (row_reg == CNT_W'(gi));
    end
  endgenerate

  // During LOAD_FILT col/row count taps and filter rows; they are cleared
  // on the way into STREAM and then count ifmap columns and output rows.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      cfg_w_reg    <= '0;
      cfg_rows_reg <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            cfg_w_reg    <= bus.cfg_w;
            cfg_rows_reg <= bus.cfg_rows;
            col_reg      <= '0;
            row_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= CHECK;
          end
        end
        CHECK: begin
          if (cfg_bad) begin
            done_reg  <= 1'b1;
            err_reg   <= 1'b1;
            state_reg <= FINISH;
          end else begin
            in_ready_reg <= 1'b1;
            state_reg    <= LOAD_FILT;
          end
        end
        LOAD_FILT: begin
          if (fire) begin
            if (col_reg == CNT_W'(FILT_TAPS - 1)) begin
              col_reg <= '0;
              if (row_reg == CNT_W'(NUM_ROWS - 1)) begin
                row_reg   <= '0;
                state_reg <= STREAM;
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        STREAM: begin
          if (fire) begin
            if (col_reg == w_last) begin
              col_reg <= '0;
              if (row_reg == rows_last) begin
                in_ready_reg <= 1'b0;
                state_reg    <= DRAIN;
              end else begin
                row_reg <= row_reg + 1'b1;
              end
            end else begin
              col_reg <= col_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            done_reg  <= 1'b1;
            state_reg <= FINISH;
          end
        end
        FINISH: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.PERead    = wave_all;
  assign bus.PEStart   = st_all;
  assign bus.out_valid = ov_all[PE_LAT];
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_busy_reg;
  logic [15:0] perf_stall_reg;

  // Outside a job neither condition holds, so the totals stay readable after done.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else if ((state_reg == IDLE) && bus.start) begin
      perf_busy_reg  <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (busy_reg && (perf_busy_reg != 16'hFFFF)) begin
        perf_busy_reg <= perf_busy_reg + 16'd1;
      end
      if (in_ready_reg && !bus.in_valid && (perf_stall_reg != 16'hFFFF)) begin
        perf_stall_reg <= perf_stall_reg + 16'd1;
      end
    end
  end

  assign perf_busy_cycles  = perf_busy_reg;
  assign perf_stall_cycles = perf_stall_reg;
`endif

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: a job-level model pushes expected
// strobe cycles per channel, a negedge monitor pops and compares.
module tb_pe_array_sequencer;
  localparam int FILT_TAPS = 3;
  localparam int PE_LAT    = 2;
  localparam int CNT_W     = 8;
  localparam int NCH       = 16;
  localparam int BIG       = 32'h7fffffff;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  pe_array_sequencer_if #(.CNT_W(CNT_W)) bus ();

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] perf_busy_cycles;
  logic [15:0] perf_stall_cycles;
`endif

  pe_array_sequencer #(
    .FILT_TAPS(FILT_TAPS),
    .PE_LAT   (PE_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .nRST(nRST),
    .bus (bus)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Channels: 0-4 PERead[g], 5-9 PEStart[g], 10-12 filtRead[r], 13 out_valid, 14 done, 15 err
  int exp_q[NCH][$];
  int vectors = 0;
  int miscompares = 0;
  int busy_lo = 1, busy_hi = 0, rdy_lo = 1, rdy_hi = 0;
  int perf_chk = -1;
  int exp_perf_busy = 0, exp_perf_stall = 0;
  int jobs = 0;
  bit mon_en = 1'b0;

  function automatic string ch_name(input int ch);
    if (ch < 5)   return $sformatf("PERead[%0d]", ch);
    if (ch < 10)  return $sformatf("PEStart[%0d]", ch - 5);
    if (ch < 13)  return $sformatf("filtRead[%0d]", ch - 10);
    if (ch == 13) return "out_valid";
    if (ch == 14) return "done";
    return "err";
  endfunction

  task automatic check_cycle();
    logic [NCH-1:0] obs;
    bit exp_b, exp_r;
    obs = {bus.err, bus.done, bus.out_valid, bus.filtRead, bus.PEStart, bus.PERead};
    for (int ch = 0; ch < NCH; ch++) begin
      while (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
        vectors++; miscompares++;
        $display("FAIL %s missed: got=none exp_cyc=%0d now=%0d", ch_name(ch), exp_q[ch][0], cyc);
        void'(exp_q[ch].pop_front());
      end
      if (exp_q[ch].size() > 0 && exp_q[ch][0] == cyc) begin
        vectors++;
        void'(exp_q[ch].pop_front());
        if (obs[ch] !== 1'b1) begin
          miscompares++;
          $display("FAIL %s cyc=%0d got=%b exp=1", ch_name(ch), cyc, obs[ch]);
        end
      end else if (obs[ch] !== 1'b0) begin
        vectors++; miscompares++;
        $display("FAIL %s unexpected cyc=%0d got=%b exp=0", ch_name(ch), cyc, obs[ch]);
      end
    end
    exp_b = (cyc >= busy_lo) && (cyc <= busy_hi);
    exp_r = (cyc >= rdy_lo) && (cyc <= rdy_hi);
    vectors++;
    if (bus.busy !== exp_b) begin
      miscompares++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, exp_b);
    end
    vectors++;
    if (bus.in_ready !== exp_r) begin
      miscompares++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_r);
    end
`ifdef SEQ_PERF_CNT_EN
    if (cyc == perf_chk) begin
      vectors += 2;
      if (perf_busy_cycles !== 16'(exp_perf_busy)) begin
        miscompares++;
        $display("FAIL perf_busy cyc=%0d got=%0d exp=%0d", cyc, perf_busy_cycles, exp_perf_busy);
      end
      if (perf_stall_cycles !== 16'(exp_perf_stall)) begin
        miscompares++;
        $display("FAIL perf_stall cyc=%0d got=%0d exp=%0d", cyc, perf_stall_cycles, exp_perf_stall);
      end
    end
`endif
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) check_cycle();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_junk(input bit hold);
    bus.start    = hold;
    bus.cfg_w    = CNT_W'($urandom);
    bus.cfg_rows = CNT_W'($urandom);
    bus.in_valid = 1'($urandom_range(1));
  endtask

  function automatic bit pick_valid(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (idx % 2) == 0;
    return $urandom_range(3) != 0;
  endfunction

  // The k-th fire of a job: the first 3*FILT_TAPS load filter rows in order,
  // the rest are ifmap beats whose column is (beat index mod width).
  task automatic expect_fire(input int k, input int w, input int c);
    int col;
    if (k < 3 * FILT_TAPS) begin
      exp_q[10 + k / FILT_TAPS].push_back(c);
    end else begin
      col = (k - 3 * FILT_TAPS) % w;
      for (int g = 0; g < 5; g++) exp_q[g].push_back(c + g);
      if (col >= FILT_TAPS - 1) begin
        for (int g = 0; g < 5; g++) exp_q[5 + g].push_back(c + g);
        exp_q[13].push_back(c + 4 + PE_LAT);
      end
    end
  endtask

  task automatic run_job(input int w, input int rows, input int mode, input bit hold,
                         input int abort_after);
    int s, k, total, l, d, stalls, idx, c;
    bit v;
    step();
    s = cyc;
    jobs++;
    $display("job %0d: cfg_w=%0d cfg_rows=%0d mode=%0d hold=%0d abort=%0d start_cyc=%0d",
             jobs, w, rows, mode, hold, abort_after, s);
    bus.start    = 1'b1;
    bus.cfg_w    = CNT_W'(w);
    bus.cfg_rows = CNT_W'(rows);
    bus.in_valid = 1'($urandom_range(1));
    busy_lo = s + 1;
    busy_hi = BIG;
    step();
    drive_junk(hold);
    if (w < FILT_TAPS || rows == 0) begin
      exp_q[14].push_back(s + 2);
      exp_q[15].push_back(s + 2);
      busy_hi = s + 2;
      exp_perf_busy = 2; exp_perf_stall = 0; perf_chk = s + 3;
      step();
      drive_junk(hold);
      return;
    end
    rdy_lo = s + 2;
    rdy_hi = BIG;
    total  = 3 * FILT_TAPS + w * rows;
    k = 0; stalls = 0; idx = 0;
    while (k < total) begin
      step();
      drive_junk(hold);
      v = pick_valid(mode, idx);
      idx++;
      bus.in_valid = v;
      if (v) begin
        expect_fire(k, w, cyc);
        k++;
      end else begin
        stalls++;
      end
      if (abort_after >= 0 && k == 3 * FILT_TAPS + abort_after) begin
        step();
        c = cyc;
        nRST = 1'b0;
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        for (int ch = 0; ch < NCH; ch++)
          while (exp_q[ch].size() > 0 && exp_q[ch][$] > c) void'(exp_q[ch].pop_back());
        busy_hi = c;
        rdy_hi  = c;
        step();
        step();
        nRST = 1'b1;
        return;
      end
    end
    l = cyc;
    rdy_hi = l;
    d = l + 4 + PE_LAT + 2;
    busy_hi = d;
    exp_q[14].push_back(d);
    exp_perf_busy = d - s; exp_perf_stall = stalls; perf_chk = d + 1;
    while (cyc < d) begin
      step();
      drive_junk(hold);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      bus.start    = 1'b0;
      bus.cfg_w    = CNT_W'($urandom);
      bus.cfg_rows = CNT_W'($urandom);
      bus.in_valid = 1'($urandom_range(1));
    end
  endtask

  initial begin
    int w, r;
    bus.start = 1'b0; bus.cfg_w = '0; bus.cfg_rows = '0; bus.in_valid = 1'b0;
    nRST = 1'b0;
    repeat (3) step();
    mon_en = 1'b1;
    step();
    step();
    nRST = 1'b1;
    idle(3);

    run_job(5, 1, 0, 1'b0, -1);
    idle(2);
    run_job(4, 3, 1, 1'b0, -1);
    idle(2);
    run_job(2, 4, 0, 1'b0, -1);
    idle(2);
    run_job(7, 0, 0, 1'b0, -1);
    idle(2);
    run_job(5, 2, 0, 1'b0, 2);
    idle(2);
    run_job(6, 2, 2, 1'b0, -1);
    run_job(3, 2, 0, 1'b1, -1);
    run_job(5, 1, 2, 1'b1, -1);
    idle(3);
    run_job(255, 2, 0, 1'b0, -1);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(1, 9);
      r = $urandom_range(0, 3);
      run_job(w, r, $urandom_range(2), 1'($urandom_range(1)), -1);
      idle($urandom_range(0, 2));
    end
    idle(12);
    for (int ch = 0; ch < NCH; ch++) begin
      vectors++;
      if (exp_q[ch].size() != 0) begin
        miscompares++;
        $display("FAIL %s leftover: got=none exp_count=%0d", ch_name(ch), exp_q[ch].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
